rr_grant_arbiter_8: RTL and testbench
=====================================

Name: rr_grant_arbiter_8

Overview:
- Sequential arbiter sharing one resource among 8 requesters.
- Each cycle in IDLE it selects a winner, using either fixed priority (highest index wins, matching the team's 8-to-3 priority encoder convention) or round-robin.
- It holds the grant until the owner releases its request or a hold timeout preempts it.
- Sits in front of any shared datapath slice (bus, ALU, memory port); the encoded grant index drives that slice's select lines.

Parameters:
- MAX_HOLD, 16: max consecutive GRANT cycles per owner; 0 disables timeout; legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- rr_en  input  1  1 = round-robin, 0 = fixed priority; sampled only on IDLE arbitration cycles.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of owner, registered; valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active (equals |gnt).
- preempt  output  1  one-cycle pulse: previous grant was revoked by timeout.

Behaviour:
- Reset (async assert, sync-release use): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0, last_owner=0.
  - Reset mid-grant drops gnt immediately (asynchronously).
- FSM has two states, IDLE and GRANT.
- IDLE:
  - gnt=0.
  - If req!=0: winner computed combinationally; next edge loads gnt/gnt_idx, sets gnt_valid, clears hold_cnt, goes to GRANT.
  - Latency req->gnt is 1 cycle.
  - If req==0: stay in IDLE.
- Winner selection, k = last_owner:
  - Fixed (rr_en=0): highest set bit of req.
  - RR (rr_en=1): masked = req & ((1<<k)-1). If masked!=0, highest set bit of masked; else highest set bit of req.
  - Net RR order after owner k: k-1 down to 0, then 7 down to k.
  - Pointer reset value 0 makes the first RR decision equal to fixed priority.
- GRANT:
  - gnt held stable; hold_cnt increments each cycle (8-bit, saturating at 255).
  - Release: req[gnt_idx]==0 -> next edge goes to IDLE, gnt=0, last_owner<=gnt_idx, preempt=0.
  - Timeout: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and req[gnt_idx]==1 -> next edge goes to IDLE, gnt=0, last_owner<=gnt_idx, preempt=1 for exactly that one IDLE cycle.
  - Release and timeout in the same cycle -> treated as release (preempt=0).
  - Changes to non-owner req bits during GRANT are ignored.
- Mandatory one-cycle gap (IDLE) between consecutive grants. A resource owner therefore holds at most MAX_HOLD cycles out of every MAX_HOLD+1.
- Fixed mode after a timeout: the same requester wins again if it is still highest. Starvation is allowed in fixed mode by design.
- RR mode after a timeout: the preempted requester becomes lowest priority.
- gnt is always one-hot or zero. gnt_idx holds its last value while gnt_valid=0.
- No combinational path from req to any output.

Decomposition:
- Shared package/include file holds:
  - N_REQ=8, IDX_W=3, HOLD_W=8.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- One combinational sub-module, rr_masked_encoder:
  - Inputs: req[7:0], ptr[2:0], rr_en.
  - Outputs: idx[2:0], any.
  - Internally two 8-to-3 highest-first encoders (masked and unmasked) plus a select mux.
- Top level holds the FSM, hold counter, pointer and output registers.

Test Plan:
1. Reset then req=8'b0010_0100, rr_en=0 -> after 1 cycle gnt=8'b0010_0000, gnt_idx=5, gnt_valid=1; deassert req[5] -> next cycle gnt=0; the cycle after, gnt_idx=2.
2. RR fairness: rr_en=1, req=8'hFF held constant, each owner drops its req for 1 cycle after 2 cycles of grant, then reasserts -> grant order 7,6,5,4,3,2,1,0,7 with one idle cycle between grants.
3. Timeout: MAX_HOLD=4, rr_en=1, req=8'b1000_0001 held -> gnt_idx=7 for exactly 4 cycles, then gnt=0 with preempt=1 for one cycle, then gnt_idx=0 for 4 cycles, then 7 again.
4. Fixed-mode re-win: MAX_HOLD=4, rr_en=0, req=8'b1000_0001 held -> requester 7 granted 4 cycles, gap with preempt=1, requester 7 granted again; requester 0 never granted.
5. Reset mid-grant: assert rst_n=0 asynchronously (between clock edges) during GRANT -> gnt=0, gnt_valid=0 immediately. Release with req=8'h01, rr_en=1 -> gnt_idx=0 one cycle after release (pointer back to 0).
6. Release/timeout coincidence: MAX_HOLD=3, owner drops req in its 3rd GRANT cycle -> preempt stays 0; non-owner req changes during GRANT leave gnt unchanged.

Source files
------------

// File: rtl/rr_grant_arbiter_8_pkg.sv
// Shared widths, FSM encoding and the highest-first encode helper for the 8-way arbiter.
package rr_grant_arbiter_8_pkg;

   localparam int unsigned N_REQ  = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Index of the highest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] hi_idx(input logic [N_REQ-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_8_rr_masked_encoder.sv
// Winner select: highest requester, or in round-robin mode the highest one below the pointer
// first, falling back to the highest overall when nothing sits below the pointer.
module rr_masked_encoder
   import rr_grant_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr_en,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] masked;
   logic [IDX_W-1:0] idx_masked;
   logic [IDX_W-1:0] idx_full;

   // Two highest-first encoders plus the mode/fallback mux.
   always_comb begin
      mask       = (N_REQ'(1) << ptr) - N_REQ'(1);
      masked     = req & mask;
      idx_masked = hi_idx(masked);
      idx_full   = hi_idx(req);
      idx        = (rr_en && (|masked)) ? idx_masked : idx_full;
      any        = |req;
   end

endmodule

// File: rtl/rr_grant_arbiter_8.sv
// 8-requester arbiter: grant held until release or hold timeout, one idle cycle between grants.
module rr_grant_arbiter_8
   import rr_grant_arbiter_8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             rr_en,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam bit               TMO_EN    = (MAX_HOLD != 32'd0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 32'd0) ? 32'd0 : MAX_HOLD - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [N_REQ-1:0]  gnt_d;
   logic [IDX_W-1:0]  idx_d;
   logic              valid_d;
   logic              preempt_d;
   logic [IDX_W-1:0]  win_idx;
   logic              win_any;
   logic              owner_req;

   rr_masked_encoder u_enc (
      .req   (req),
      .ptr   (last_q),
      .rr_en (rr_en),
      .idx   (win_idx),
      .any   (win_any)
   );

   assign owner_req = req[gnt_idx];

   // Next-state, hold counter, pointer and output register inputs.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      last_d    = last_q;
      gnt_d     = gnt;
      idx_d     = gnt_idx;
      valid_d   = gnt_valid;
      preempt_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               state_d = ST_GRANT;
               gnt_d   = N_REQ'(1) << win_idx;
               idx_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            if (!owner_req) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               last_d  = gnt_idx;
            end else if (TMO_EN && (hold_q == HOLD_LAST)) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               valid_d   = 1'b0;
               last_d    = gnt_idx;
               preempt_d = 1'b1;
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, bookkeeping and registered outputs; reset drops the grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         last_q    <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
         gnt       <= gnt_d;
         gnt_idx   <= idx_d;
         gnt_valid <= valid_d;
         preempt   <= preempt_d;
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Directed bench for rr_grant_arbiter_8: three instances with hold limits 16, 4 and 3 share stimulus.
module tb_rr_grant_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       rr_en;

   logic [7:0] g16, g4, g3;
   logic [2:0] i16, i4, i3;
   logic       v16, v4, v3;
   logic       p16, p4, p3;

   int checks;
   int failures;
   int expi;

   rr_grant_arbiter_8 #(.MAX_HOLD(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
      .gnt(g16), .gnt_idx(i16), .gnt_valid(v16), .preempt(p16));

   rr_grant_arbiter_8 #(.MAX_HOLD(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
      .gnt(g4), .gnt_idx(i4), .gnt_valid(v4), .preempt(p4));

   rr_grant_arbiter_8 #(.MAX_HOLD(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
      .gnt(g3), .gnt_idx(i3), .gnt_valid(v3), .preempt(p3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      req      = 8'h00;
      rr_en    = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_gnt",     32'(g16), 32'h0);
      chk("rst_idx",     32'(i16), 32'h0);
      chk("rst_valid",   32'(v16), 32'h0);
      chk("rst_preempt", 32'(p16), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fixed priority: highest index wins, then next winner after release.
      req = 8'b0010_0100; rr_en = 1'b0;
      tick();
      chk("t1_gnt",   32'(g16), 32'h20);
      chk("t1_idx",   32'(i16), 32'd5);
      chk("t1_valid", 32'(v16), 32'd1);
      req = 8'b0000_0100;
      tick();
      chk("t1_rel_gnt",   32'(g16), 32'h0);
      chk("t1_rel_valid", 32'(v16), 32'd0);
      chk("t1_rel_idx",   32'(i16), 32'd5);
      tick();
      chk("t1_next_idx", 32'(i16), 32'd2);
      chk("t1_next_gnt", 32'(g16), 32'h04);
      req = 8'h00;
      do_reset();

      // Round-robin with all requesting: 7,6,...,0,7 with an idle gap each time.
      rr_en = 1'b1; req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         expi = (i == 8) ? 7 : 7 - i;
         tick();
         chk("t2_idx",   32'(i16), 32'(expi));
         chk("t2_gnt",   32'(g16), 32'd1 << expi);
         tick();
         chk("t2_hold",  32'(i16), 32'(expi));
         req = 8'hFF & ~(8'd1 << expi);
         tick();
         chk("t2_gap_valid",   32'(v16), 32'd0);
         chk("t2_gap_preempt", 32'(p16), 32'd0);
         req = 8'hFF;
      end
      req = 8'h00; rr_en = 1'b0;
      do_reset();

      // Timeout in round-robin mode alternates 7 and 0, four cycles each.
      rr_en = 1'b1; req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_own7_idx",   32'(i4), 32'd7);
         chk("t3_own7_valid", 32'(v4), 32'd1);
         chk("t3_own7_pre",   32'(p4), 32'd0);
      end
      tick();
      chk("t3_pre1",       32'(p4), 32'd1);
      chk("t3_pre1_valid", 32'(v4), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_own0_idx",   32'(i4), 32'd0);
         chk("t3_own0_valid", 32'(v4), 32'd1);
         chk("t3_own0_pre",   32'(p4), 32'd0);
      end
      tick();
      chk("t3_pre2", 32'(p4), 32'd1);
      tick();
      chk("t3_back7_idx",   32'(i4), 32'd7);
      chk("t3_back7_valid", 32'(v4), 32'd1);
      chk("t3_back7_pre",   32'(p4), 32'd0);
      req = 8'h00;
      do_reset();

      // Timeout in fixed mode: requester 7 wins again, requester 0 starves.
      rr_en = 1'b0; req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_first_gnt", 32'(g4), 32'h80);
      end
      tick();
      chk("t4_pre",       32'(p4), 32'd1);
      chk("t4_pre_valid", 32'(v4), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_rewin_gnt", 32'(g4), 32'h80);
         chk("t4_rewin_pre", 32'(p4), 32'd0);
      end
      tick();
      chk("t4_pre2", 32'(p4), 32'd1);
      req = 8'h00;
      do_reset();

      // Asynchronous reset mid-grant, then pointer restarts at 0.
      rr_en = 1'b0; req = 8'h81;
      tick();
      chk("t5_pre_rst_idx", 32'(i16), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_gnt",   32'(g16), 32'h0);
      chk("t5_async_valid", 32'(v16), 32'd0);
      req = 8'h01; rr_en = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("t5_after_idx", 32'(i16), 32'd0);
      chk("t5_after_gnt", 32'(g16), 32'h01);
      req = 8'h00;
      do_reset();

      // Release coinciding with timeout is a release; non-owner changes ignored.
      rr_en = 1'b0; req = 8'h10;
      tick();
      chk("t6_gnt1", 32'(g3), 32'h10);
      req = 8'h90;
      tick();
      chk("t6_nonowner_gnt", 32'(g3), 32'h10);
      req = 8'h91;
      tick();
      chk("t6_third_gnt", 32'(g3), 32'h10);
      chk("t6_third_idx", 32'(i3), 32'd4);
      req = 8'h81;
      tick();
      chk("t6_rel_valid", 32'(v3), 32'd0);
      chk("t6_rel_pre",   32'(p3), 32'd0);
      chk("t6_rel_gnt",   32'(g3), 32'h0);
      tick();
      chk("t6_next_gnt", 32'(g3), 32'h80);
      chk("t6_next_idx", 32'(i3), 32'd7);
      chk("t6_next_pre", 32'(p3), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
